// File: rtl/sort_four_floats_shared_cmp_if.sv
// Operand/result bundle for the four-double sorter.
// The requester drives arg_vld/unsorted. The sorter returns arg_rdy/res_vld/sorted/err.
interface sort_four_floats_shared_cmp_if #(
    parameter int unsigned FLEN = 64
);
    logic                 arg_vld;
    logic                 arg_rdy;
    logic [0:3][FLEN-1:0] unsorted;
    logic                 res_vld;
    logic [0:3][FLEN-1:0] sorted;
    logic                 err;

    modport master (
        output arg_vld,
        output unsorted,
        input  arg_rdy,
        input  res_vld,
        input  sorted,
        input  err
    );

    modport slave (
        input  arg_vld,
        input  unsorted,
        output arg_rdy,
        output res_vld,
        output sorted,
        output err
    );
endinterface

// File: rtl/sort_four_floats_shared_cmp.sv
// Four-entry ascending sort of IEEE-754 doubles.
// A five-compare network runs through one shared a<=b comparator.
// Any NaN or infinity operand aborts the sort. The partially ordered buffer is then returned with err=1.

// Combinational a <= b for doubles.
// err flags a NaN/infinity operand (exponent all ones).
// +0.0 and -0.0 compare equal.
module f_less_or_equal #(
    parameter int unsigned FLEN = 64
) (
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);
    localparam int unsigned EW = 11;

    logic            a_sign;
    logic            b_sign;
    logic [EW-1:0]   a_exp;
    logic [EW-1:0]   b_exp;
    logic [FLEN-2:0] a_mag;
    logic [FLEN-2:0] b_mag;

    assign a_sign = a[FLEN-1];
    assign b_sign = b[FLEN-1];
    assign a_exp  = a[FLEN-2 -: EW];
    assign b_exp  = b[FLEN-2 -: EW];
    assign a_mag  = a[FLEN-2:0];
    assign b_mag  = b[FLEN-2:0];

    // Sign/magnitude ordering; both zeros are equal regardless of sign.
    always_comb begin
        res = 1'b0;
        err = (&a_exp) | (&b_exp);
        if ((a_mag == '0) && (b_mag == '0)) begin
            res = 1'b1;
        end else if (a_sign != b_sign) begin
            res = a_sign;
        end else if (!a_sign) begin
            res = (a_mag <= b_mag);
        end else begin
            res = (a_mag >= b_mag);
        end
    end
endmodule

module sort_four_floats_shared_cmp #(
    parameter int unsigned FLEN = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    sort_four_floats_shared_cmp_if.slave   io
);
    typedef enum logic [2:0] {
        IDLE,
        CMP0,
        CMP1,
        CMP2,
        CMP3,
        CMP4,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [0:3][FLEN-1:0] buff;
    logic [0:3][FLEN-1:0] buff_nxt;
    logic [0:3][FLEN-1:0] sorted_q;
    logic [0:3][FLEN-1:0] sorted_nxt;
    logic                 err_q;
    logic                 err_nxt;

    logic [1:0]           idx_i;
    logic [1:0]           idx_j;
    logic [FLEN-1:0]      cmp_a;
    logic [FLEN-1:0]      cmp_b;
    logic                 cmp_res;
    logic                 cmp_err;

    // Compare schedule: the operand pair fed to the shared comparator in each state.
    always_comb begin
        idx_i = 2'd0;
        idx_j = 2'd1;
        case (state)
            CMP0:    begin idx_i = 2'd0; idx_j = 2'd1; end
            CMP1:    begin idx_i = 2'd2; idx_j = 2'd3; end
            CMP2:    begin idx_i = 2'd0; idx_j = 2'd2; end
            CMP3:    begin idx_i = 2'd1; idx_j = 2'd3; end
            CMP4:    begin idx_i = 2'd1; idx_j = 2'd2; end
            default: begin idx_i = 2'd0; idx_j = 2'd1; end
        endcase
    end

    assign cmp_a = buff[idx_i];
    assign cmp_b = buff[idx_j];

    f_less_or_equal #(.FLEN(FLEN)) u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .res (cmp_res),
        .err (cmp_err)
    );

    // Next state, buffer swap and result capture.
    always_comb begin
        state_nxt  = state;
        buff_nxt   = buff;
        sorted_nxt = sorted_q;
        err_nxt    = err_q;
        case (state)
            IDLE: begin
                if (io.arg_vld) begin
                    buff_nxt  = io.unsorted;
                    state_nxt = CMP0;
                end
            end
            CMP0, CMP1, CMP2, CMP3, CMP4: begin
                if (cmp_err) begin
                    state_nxt  = DONE;
                    err_nxt    = 1'b1;
                    sorted_nxt = buff;
                end else begin
                    if (!cmp_res) begin
                        buff_nxt[idx_i] = buff[idx_j];
                        buff_nxt[idx_j] = buff[idx_i];
                    end
                    case (state)
                        CMP0:    state_nxt = CMP1;
                        CMP1:    state_nxt = CMP2;
                        CMP2:    state_nxt = CMP3;
                        CMP3:    state_nxt = CMP4;
                        default: state_nxt = DONE;
                    endcase
                    // The final compare's swap lands in the result at the same edge.
                    if (state == CMP4) begin
                        err_nxt    = 1'b0;
                        sorted_nxt = buff_nxt;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, working buffer and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            buff     <= '0;
            sorted_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            buff     <= buff_nxt;
            sorted_q <= sorted_nxt;
            err_q    <= err_nxt;
        end
    end

    assign io.arg_rdy = (state == IDLE);
    assign io.res_vld = (state == DONE);
    assign io.sorted  = sorted_q;
    assign io.err     = err_q;
endmodule

// File: tb/tb_sort_four_floats_shared_cmp.sv
// Directed bench for the four-double sorter.
// It runs a vector table through single transactions.
// It then runs back-to-back accepts and a reset abort in CMP2.
module tb_sort_four_floats_shared_cmp;
    localparam int unsigned FLEN = 64;

    typedef struct {
        string                name;
        logic [0:3][FLEN-1:0] in_v;
        logic [0:3][FLEN-1:0] exp_v;
        logic                 exp_err;
        int unsigned          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    sort_four_floats_shared_cmp_if #(.FLEN(FLEN)) io ();

    sort_four_floats_shared_cmp #(.FLEN(FLEN)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] NAN_X  = 64'hFFF123456789abcd;
    localparam logic [63:0] PINF   = 64'h7FF0000000000000;
    localparam logic [63:0] NINF   = 64'hFFF0000000000000;
    localparam logic [63:0] PZERO  = 64'h0000000000000000;
    localparam logic [63:0] NZERO  = 64'h8000000000000000;

    vec_t vecs [8];

    function automatic logic [63:0] d(input real r);
        return $realtobits(r);
    endfunction

    function automatic vec_t mk(input string name,
                                input logic [63:0] i0, input logic [63:0] i1,
                                input logic [63:0] i2, input logic [63:0] i3,
                                input logic [63:0] e0, input logic [63:0] e1,
                                input logic [63:0] e2, input logic [63:0] e3,
                                input logic e_err, input int unsigned lat);
        vec_t v;
        v.name    = name;
        v.in_v    = {i0, i1, i2, i3};
        v.exp_v   = {e0, e1, e2, e3};
        v.exp_err = e_err;
        v.exp_lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // From just after the accept edge: count edges until res_vld, then check the result and the pulse width.
    task automatic wait_result(input vec_t v);
        int unsigned lat;
        bit          seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (io.res_vld) seen = 1'b1;
        end
        check({v.name, " latency"}, 256'(lat), 256'(v.exp_lat));
        check({v.name, " sorted"}, io.sorted, v.exp_v);
        check({v.name, " err"}, 256'(io.err), 256'(v.exp_err));
        @(negedge clk);
        check({v.name, " res_vld pulse"}, 256'(io.res_vld), 256'(0));
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check({v.name, " arg_rdy"}, 256'(io.arg_rdy), 256'(1));
        io.unsorted = v.in_v;
        io.arg_vld  = 1'b1;
        @(posedge clk);
        #1 io.arg_vld = 1'b0;
        wait_result(v);
    endtask

    initial begin
        vec_t va;
        vec_t vb;
        int   n;
        bit   acc;

        vecs[0] = mk("desc4321", d(4.0), d(3.0), d(2.0), d(1.0),
                     d(1.0), d(2.0), d(3.0), d(4.0), 1'b0, 5);
        vecs[1] = mk("dup123", d(1.23), d(1.23), d(-1.23), d(-1.23),
                     d(-1.23), d(-1.23), d(1.23), d(1.23), 1'b0, 5);
        vecs[2] = mk("mixedexp", d(1.23e-5), d(-1.23e5), d(1.23), d(-1.23),
                     d(-1.23e5), d(-1.23), d(1.23e-5), d(1.23), 1'b0, 5);
        vecs[3] = mk("signedzero", NZERO, PZERO, d(5.0), d(-5.0),
                     d(-5.0), PZERO, NZERO, d(5.0), 1'b0, 5);
        vecs[4] = mk("ascending", d(1.0), d(2.0), d(3.0), d(4.0),
                     d(1.0), d(2.0), d(3.0), d(4.0), 1'b0, 5);
        vecs[5] = mk("nan_cmp1", d(1.0), d(2.0), NAN_X, d(0.5),
                     d(1.0), d(2.0), NAN_X, d(0.5), 1'b1, 2);
        vecs[6] = mk("pinf_cmp0", PINF, d(1.0), d(2.0), d(3.0),
                     PINF, d(1.0), d(2.0), d(3.0), 1'b1, 1);
        vecs[7] = mk("ninf_b_cmp0", d(1.0), NINF, d(2.0), d(3.0),
                     d(1.0), NINF, d(2.0), d(3.0), 1'b1, 1);

        io.arg_vld  = 1'b0;
        io.unsorted = '0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset arg_rdy", 256'(io.arg_rdy), 256'(1));
        check("reset res_vld", 256'(io.res_vld), 256'(0));
        check("reset err", 256'(io.err), 256'(0));
        check("reset sorted", io.sorted, 256'(0));
        rst = 1'b0;

        // The first vector is accepted on the first rising edge after reset release.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: arg_vld stays high and the second set waits for arg_rdy.
        va = mk("b2b_a", d(-2.5), d(7.0), d(0.0), d(-100.0),
                d(-100.0), d(-2.5), d(0.0), d(7.0), 1'b0, 5);
        vb = vecs[6];
        vb.name = "b2b_b";
        @(negedge clk);
        check("b2b first arg_rdy", 256'(io.arg_rdy), 256'(1));
        io.unsorted = va.in_v;
        io.arg_vld  = 1'b1;
        @(posedge clk);
        #1 io.unsorted = vb.in_v;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 6) begin
                check("b2b_a res_vld", 256'(io.res_vld), 256'(1));
                check("b2b_a sorted", io.sorted, va.exp_v);
                check("b2b_a err", 256'(io.err), 256'(0));
            end
            if (io.arg_rdy) acc = 1'b1;
        end
        check("b2b arg_rdy low cycles", 256'(n), 256'(7));
        @(posedge clk);
        #1 io.arg_vld = 1'b0;
        wait_result(vb);

        // Reset during CMP2 aborts the sort with no result pulse.
        @(negedge clk);
        io.unsorted = vecs[0].in_v;
        io.arg_vld  = 1'b1;
        @(posedge clk);
        #1 io.arg_vld = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort arg_rdy", 256'(io.arg_rdy), 256'(1));
        check("abort res_vld", 256'(io.res_vld), 256'(0));
        check("abort err", 256'(io.err), 256'(0));
        check("abort sorted", io.sorted, 256'(0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("abort res_vld in reset", 256'(io.res_vld), 256'(0));
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("abort no res_vld", 256'(io.res_vld), 256'(0));
            check("abort idle arg_rdy", 256'(io.arg_rdy), 256'(1));
        end
        run_vec(vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound in case the bench stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end
endmodule
